kyber_core_seq: RTL and testbench

Operation sequencer for the Kyber core. It turns a host "go" command (a level bit from the register file, edge-detected) into a fixed sequence: a multi-cycle core reset pulse, a settle gap, a one-cycle start strobe with the latched opcode, then supervision until `core_done`. It reports busy, done, error and run-length status back to the register file, and it supports abort and a timeout watchdog.

---
 rtl/kyber_core_seq_if.sv | 27 ++
 rtl/kyber_core_seq.sv | 155 +++++++++++++++
 tb/tb_kyber_core_seq.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/kyber_core_seq_if.sv
// rtl/kyber_core_seq_if.sv - host/core handshake bundle for the Kyber operation sequencer
interface kyber_core_seq_if #(
    parameter int CNT_W = 24
);
    logic             go;
    logic [1:0]       op_in;
    logic             abort;
    logic             core_done;
    logic             core_rst;
    logic             core_start;
    logic [1:0]       core_op;
    logic             busy;
    logic             done_flag;
    logic             err_flag;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output go, op_in, abort, core_done,
        input  core_rst, core_start, core_op, busy, done_flag, err_flag, err_code, cycle_count
    );

    modport slave (
        input  go, op_in, abort, core_done,
        output core_rst, core_start, core_op, busy, done_flag, err_flag, err_code, cycle_count
    );
endinterface

// File: rtl/kyber_core_seq.sv
// rtl/kyber_core_seq.sv - go-edge driven reset/settle/start/supervise sequencer for the Kyber core
module kyber_core_seq #(
    parameter int RST_CYCLES    = 10,
    parameter int SETTLE_CYCLES = 4,
    parameter int TIMEOUT       = 100000,
    parameter int CNT_W         = 24
) (
    input  logic            clk,
    input  logic            rst,
    kyber_core_seq_if.slave io_bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_SETTLE,
        S_START,
        S_RUN
    } state_t;

    // Phase counter only has to reach the longer of the two fixed phases.
    localparam int PH_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [PH_W-1:0]  RST_LAST = PH_W'(RST_CYCLES - 1);
    localparam logic [PH_W-1:0]  SET_LAST = (SETTLE_CYCLES > 0) ? PH_W'(SETTLE_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT);

    localparam logic [1:0] OP_INVALID   = 2'b11;
    localparam logic [1:0] ERR_INVALID  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ABORT    = 2'b11;

    state_t           r_state;
    logic             r_go_prev;
    logic [1:0]       r_op;
    logic [PH_W-1:0]  r_phase_cnt;
    logic [CNT_W-1:0] r_cycle_count;
    logic             r_done_flag;
    logic             r_err_flag;
    logic [1:0]       r_err_code;

    state_t           w_state_nxt;
    logic [1:0]       w_op_nxt;
    logic [PH_W-1:0]  w_phase_nxt;
    logic [CNT_W-1:0] w_cycle_nxt;
    logic             w_done_nxt;
    logic             w_err_nxt;
    logic [1:0]       w_code_nxt;
    logic             w_go_edge;

    assign w_go_edge = io_bus.go & ~r_go_prev;

    // Register all sequencer state; reset returns everything to zero / IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_go_prev     <= 1'b0;
            r_op          <= '0;
            r_phase_cnt   <= '0;
            r_cycle_count <= '0;
            r_done_flag   <= 1'b0;
            r_err_flag    <= 1'b0;
            r_err_code    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_go_prev     <= io_bus.go;
            r_op          <= w_op_nxt;
            r_phase_cnt   <= w_phase_nxt;
            r_cycle_count <= w_cycle_nxt;
            r_done_flag   <= w_done_nxt;
            r_err_flag    <= w_err_nxt;
            r_err_code    <= w_code_nxt;
        end
    end

    // Next-state logic: abort outranks every phase transition, done and timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_phase_nxt = r_phase_cnt;
        w_cycle_nxt = r_cycle_count;
        w_done_nxt  = r_done_flag;
        w_err_nxt   = r_err_flag;
        w_code_nxt  = r_err_code;

        if ((r_state != S_IDLE) && io_bus.abort) begin
            w_state_nxt = S_IDLE;
            w_err_nxt   = 1'b1;
            w_code_nxt  = ERR_ABORT;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_go_edge) begin
                        w_done_nxt  = 1'b0;
                        w_err_nxt   = 1'b0;
                        w_code_nxt  = '0;
                        w_cycle_nxt = '0;
                        w_op_nxt    = io_bus.op_in;
                        if (io_bus.op_in == OP_INVALID) begin
                            w_err_nxt  = 1'b1;
                            w_code_nxt = ERR_INVALID;
                        end else begin
                            w_state_nxt = S_RST;
                            w_phase_nxt = '0;
                        end
                    end
                end
                S_RST: begin
                    if (r_phase_cnt == RST_LAST) begin
                        w_phase_nxt = '0;
                        w_state_nxt = (SETTLE_CYCLES == 0) ? S_START : S_SETTLE;
                    end else begin
                        w_phase_nxt = r_phase_cnt + 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (r_phase_cnt == SET_LAST) begin
                        w_phase_nxt = '0;
                        w_state_nxt = S_START;
                    end else begin
                        w_phase_nxt = r_phase_cnt + 1'b1;
                    end
                end
                S_START: begin
                    // core_done is deliberately not looked at here
                    w_state_nxt = S_RUN;
                end
                S_RUN: begin
                    if (io_bus.core_done) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end else if (r_cycle_count == TO_VAL) begin
                        w_state_nxt = S_IDLE;
                        w_err_nxt   = 1'b1;
                        w_code_nxt  = ERR_TIMEOUT;
                    end else if (r_cycle_count != '1) begin
                        w_cycle_nxt = r_cycle_count + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign io_bus.core_rst    = (r_state == S_RST);
    assign io_bus.core_start  = (r_state == S_START);
    assign io_bus.busy        = (r_state != S_IDLE);
    assign io_bus.core_op     = r_op;
    assign io_bus.done_flag   = r_done_flag;
    assign io_bus.err_flag    = r_err_flag;
    assign io_bus.err_code    = r_err_code;
    assign io_bus.cycle_count = r_cycle_count;
endmodule

// File: tb/tb_kyber_core_seq.sv
// tb/tb_kyber_core_seq.sv - self-checking bench for kyber_core_seq against a cycle-position model
module tb_kyber_core_seq;
    localparam int R  = 10;
    localparam int S  = 4;
    localparam int T0 = 100000;
    localparam int T1 = 20;
    localparam int CW = 24;
    localparam longint CNT_MAX = (64'd1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       s_rst;
    logic       s_go [2];
    logic [1:0] s_op [2];
    logic       s_ab [2];
    logic       s_dn [2];
    logic [32:0] o_vec [2];

    kyber_core_seq_if #(.CNT_W(CW)) bus0 ();
    kyber_core_seq_if #(.CNT_W(CW)) bus1 ();

    kyber_core_seq #(.RST_CYCLES(R), .SETTLE_CYCLES(S), .TIMEOUT(T0), .CNT_W(CW)) dut0 (
        .clk(clk), .rst(s_rst), .io_bus(bus0.slave)
    );
    kyber_core_seq #(.RST_CYCLES(R), .SETTLE_CYCLES(S), .TIMEOUT(T1), .CNT_W(CW)) dut1 (
        .clk(clk), .rst(s_rst), .io_bus(bus1.slave)
    );

    assign bus0.go = s_go[0]; assign bus0.op_in = s_op[0]; assign bus0.abort = s_ab[0]; assign bus0.core_done = s_dn[0];
    assign bus1.go = s_go[1]; assign bus1.op_in = s_op[1]; assign bus1.abort = s_ab[1]; assign bus1.core_done = s_dn[1];
    assign o_vec[0] = {bus0.busy, bus0.core_rst, bus0.core_start, bus0.core_op, bus0.done_flag,
                       bus0.err_flag, bus0.err_code, bus0.cycle_count};
    assign o_vec[1] = {bus1.busy, bus1.core_rst, bus1.core_start, bus1.core_op, bus1.done_flag,
                       bus1.err_flag, bus1.err_code, bus1.cycle_count};

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 0;

    // Model: m_k counts cycles since the accepted go edge (1..R reset, then S settle, then start, then run)
    bit         m_act    [2];
    bit         m_goprev [2];
    bit         m_done   [2];
    bit         m_err    [2];
    logic [1:0] m_op     [2];
    logic [1:0] m_code   [2];
    longint     m_cnt    [2];
    int         m_k      [2];

    task automatic model_step(int i);
        bit edg;
        if (s_rst) begin
            m_act[i] = 0; m_goprev[i] = 0; m_done[i] = 0; m_err[i] = 0;
            m_op[i] = 2'd0; m_code[i] = 2'd0; m_cnt[i] = 0; m_k[i] = 0;
        end else begin
            edg = s_go[i] && !m_goprev[i];
            m_goprev[i] = s_go[i];
            if (!m_act[i]) begin
                if (edg) begin
                    m_done[i] = 0; m_err[i] = 0; m_code[i] = 2'd0; m_cnt[i] = 0;
                    m_op[i] = s_op[i];
                    if (s_op[i] == 2'd3) begin
                        m_err[i] = 1; m_code[i] = 2'd1;
                    end else begin
                        m_act[i] = 1; m_k[i] = 1;
                    end
                end
            end else if (s_ab[i]) begin
                m_act[i] = 0; m_err[i] = 1; m_code[i] = 2'd3;
            end else if (m_k[i] > R + S + 1) begin
                if (s_dn[i]) begin
                    m_act[i] = 0; m_done[i] = 1;
                end else if (m_cnt[i] == ((i == 0) ? T0 : T1)) begin
                    m_act[i] = 0; m_err[i] = 1; m_code[i] = 2'd2;
                end else if (m_cnt[i] != CNT_MAX) begin
                    m_cnt[i]++;
                end
            end else begin
                m_k[i]++;
            end
        end
    endtask

    // Advance the model on the same edge the DUTs sample their inputs
    always @(posedge clk) begin
        if (s_rst) cmp_en = 1;
        for (int i = 0; i < 2; i++) model_step(i);
    end

    // Compare every output of both instances against the model each cycle
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 2; i++) begin
                logic [32:0] exp_v;
                logic [CW-1:0] ec;
                ec = m_cnt[i][CW-1:0];
                exp_v = {m_act[i], m_act[i] && (m_k[i] <= R), m_act[i] && (m_k[i] == R + S + 1),
                         m_op[i], m_done[i], m_err[i], m_code[i], ec};
                n_checks++;
                if (o_vec[i] !== exp_v) begin
                    n_fail++;
                    $display("FAIL model_cmp inst%0d t=%0t got=%h expected=%h", i, $time, o_vec[i], exp_v);
                end
            end
        end
    end

    task automatic chk(string name, longint act, longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int c;
        int rl;
        s_rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s_go[i] = 0; s_op[i] = 2'd0; s_ab[i] = 0; s_dn[i] = 0;
        end
        tick(2);
        s_rst = 1'b0;
        tick(1);
        chk("reset_busy", bus0.busy, 0);
        chk("reset_flags", {bus0.done_flag, bus0.err_flag, bus0.err_code}, 0);
        chk("reset_count", bus0.cycle_count, 0);

        // nominal encaps
        s_op[0] = 2'd1; s_go[0] = 1;
        tick(1);
        rl = 0;
        for (c = 0; c < 40; c++) begin
            if (bus0.core_start) break;
            if (bus0.core_rst) rl++;
            tick(1);
        end
        chk("nom_rst_len", rl, 10);
        chk("nom_start_latency", c, 14);
        chk("nom_core_op", bus0.core_op, 1);
        tick(37);
        s_dn[0] = 1;
        tick(1);
        s_dn[0] = 0;
        chk("nom_done", bus0.done_flag, 1);
        chk("nom_busy", bus0.busy, 0);
        chk("nom_count", bus0.cycle_count, 36);
        chk("nom_model_count", m_cnt[0], 36);

        // invalid op
        s_go[0] = 0; tick(1);
        s_op[0] = 2'd3; s_go[0] = 1;
        tick(1);
        chk("inv_err", bus0.err_flag, 1);
        chk("inv_code", bus0.err_code, 1);
        chk("inv_busy", bus0.busy, 0);
        chk("inv_core_rst", bus0.core_rst, 0);
        chk("inv_done_cleared", bus0.done_flag, 0);
        s_go[0] = 0; tick(3);

        // timeout on the short-timeout instance
        s_op[1] = 2'd0; s_go[1] = 1;
        tick(1);
        for (c = 0; c < 60; c++) begin
            if (!bus1.busy) break;
            tick(1);
        end
        chk("to_busy_len", c, 36);
        chk("to_code", bus1.err_code, 2);
        chk("to_count", bus1.cycle_count, 20);
        chk("to_model_code", m_code[1], 2);
        s_go[1] = 0; tick(1);

        // abort and core_done in the same cycle
        s_op[0] = 2'd2; s_go[0] = 1;
        tick(21);
        s_ab[0] = 1; s_dn[0] = 1;
        tick(1);
        s_ab[0] = 0; s_dn[0] = 0;
        chk("col_code", bus0.err_code, 3);
        chk("col_done", bus0.done_flag, 0);
        chk("col_busy", bus0.busy, 0);

        // go edge while busy is ignored
        s_go[0] = 0; tick(1);
        s_op[0] = 2'd1; s_go[0] = 1;
        tick(1);
        s_go[0] = 0; tick(2);
        s_op[0] = 2'd2; s_go[0] = 1;
        tick(2);
        chk("busy_go_op", bus0.core_op, 1);
        chk("busy_go_busy", bus0.busy, 1);
        s_ab[0] = 1; tick(1); s_ab[0] = 0;
        s_go[0] = 0; tick(1);

        // reset mid-RST with go held high
        s_op[0] = 2'd1; s_go[0] = 1;
        tick(4);
        chk("mid_rst_pre", bus0.core_rst, 1);
        s_rst = 1; tick(1);
        chk("mid_rst_drop", bus0.core_rst, 0);
        s_rst = 0;
        tick(1);
        rl = 0;
        for (c = 0; c < 20; c++) begin
            if (!bus0.core_rst) break;
            rl++;
            tick(1);
        end
        chk("mid_rst_repulse", rl, 10);
        s_ab[0] = 1; tick(1); s_ab[0] = 0;
        s_go[0] = 0; tick(1);

        // back-to-back keygen then decaps
        s_op[0] = 2'd0; s_go[0] = 1;
        tick(1);
        for (c = 0; c < 40; c++) begin
            if (bus0.core_start) break;
            tick(1);
        end
        chk("b2b_start_seen", c, 14);
        tick(5);
        s_dn[0] = 1; tick(1); s_dn[0] = 0;
        chk("b2b_first_done", bus0.done_flag, 1);
        chk("b2b_first_count", bus0.cycle_count, 4);
        chk("b2b_first_op", bus0.core_op, 0);
        s_go[0] = 0; tick(1);
        s_op[0] = 2'd2; s_go[0] = 1;
        tick(1);
        chk("b2b_flags_clear", {bus0.done_flag, bus0.err_flag}, 0);
        chk("b2b_second_op", bus0.core_op, 2);
        chk("b2b_count_restart", bus0.cycle_count, 0);
        s_ab[0] = 1; tick(1); s_ab[0] = 0;
        s_go[0] = 0; tick(1);

        // randomized traffic on both instances, checked by the per-cycle compare
        for (int n = 0; n < 3000; n++) begin
            s_rst = ($urandom_range(0, 499) == 0);
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 5) == 0) s_go[i] = ~s_go[i];
                s_op[i] = 2'($urandom_range(0, 3));
                s_ab[i] = ($urandom_range(0, 59) == 0);
                s_dn[i] = ($urandom_range(0, 29) == 0);
            end
            tick(1);
        end
        s_rst = 0;
        for (int i = 0; i < 2; i++) begin
            s_ab[i] = 0; s_dn[i] = 0;
        end
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
